commit_unit: RTL and testbench

//  In-order retirement stage directly downstream of reorder_buffer.
//  - Consumes the ROB head entry and pops it when it retires.
//  - Writes results to the register file and releases committed stores to the store buffer.
//  - On a faulting head: captures exception state, flushes the pipeline, redirects fetch to the handler.

---
 rtl/commit_unit.sv | 201 ++++++++++++++++++++
 tb/tb_commit_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage fed by the reorder buffer head.
// Pops the head when it retires, writes the register file, releases committed
// stores, and on a faulting head captures exception state, flushes and
// redirects fetch to the handler.
// Optional feature macro: COMMIT_PERF_CNT_EN adds retired/exception counters.
module commit_unit #(
    parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_2000,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_rob_ready,
    input  logic [31:0] in_rob_value,
    input  logic [31:0] in_rob_miss_addr,
    input  logic [31:0] in_rob_PC,
    input  logic [4:0]  in_rob_rd,
    input  logic [2:0]  in_rob_exception,
    input  logic [2:0]  in_rob_instr_type,
    input  logic        in_stall,
    output logic        out_rob_pop,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_rd,
    output logic [31:0] out_rf_data,
    output logic        out_sb_commit,
    output logic        out_flush,
    output logic        out_redirect,
    output logic [31:0] out_redirect_PC,
    output logic [31:0] out_exc_PC,
    output logic [31:0] out_exc_addr,
`ifdef COMMIT_PERF_CNT_EN
    output logic [2:0]  out_exc_cause,
    output logic [31:0] out_retired_cnt,
    output logic [15:0] out_exc_cnt
`else
    output logic [2:0]  out_exc_cause
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] TYPE_ALU    = 3'b000;
    localparam logic [2:0] TYPE_LOAD   = 3'b001;
    localparam logic [2:0] TYPE_STORE  = 3'b010;
    localparam logic [2:0] TYPE_MUL    = 3'b100;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               retire_s;
    logic               exc_s;
    logic               writes_rf_s;

    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_rd_q, rf_rd_d;
    logic [31:0]        rf_data_q, rf_data_d;
    logic               sb_commit_q, sb_commit_d;
    logic               flush_q, flush_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [31:0]        exc_pc_q, exc_pc_d;
    logic [31:0]        exc_addr_q, exc_addr_d;
    logic [2:0]         exc_cause_q, exc_cause_d;

    // Retire decode: stall always wins, and nothing retires while flushing.
    always_comb begin
        retire_s    = (state_q == ST_RUN) && in_rob_ready && !in_stall;
        exc_s       = (in_rob_exception != 3'b000);
        writes_rf_s = ((in_rob_instr_type == TYPE_ALU) ||
                       (in_rob_instr_type == TYPE_LOAD) ||
                       (in_rob_instr_type == TYPE_MUL)) && (in_rob_rd != 5'd0);
    end

    assign out_rob_pop = retire_s;

    // FSM next state: a faulting retire enters FLUSH for FLUSH_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (retire_s && exc_s) begin
                    state_d = ST_FLUSH;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output next values: strobes are one-cycle pulses, exception state holds.
    always_comb begin
        rf_we_d       = 1'b0;
        rf_rd_d       = rf_rd_q;
        rf_data_d     = rf_data_q;
        sb_commit_d   = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = 32'h0000_0000;
        exc_pc_d      = exc_pc_q;
        exc_addr_d    = exc_addr_q;
        exc_cause_d   = exc_cause_q;
        flush_d       = (state_d == ST_FLUSH);
        if (retire_s && !exc_s) begin
            rf_we_d     = writes_rf_s;
            rf_rd_d     = in_rob_rd;
            rf_data_d   = in_rob_value;
            sb_commit_d = (in_rob_instr_type == TYPE_STORE);
        end else if (retire_s && exc_s) begin
            redirect_d    = 1'b1;
            redirect_pc_d = EXC_HANDLER_PC;
            exc_pc_d      = in_rob_PC;
            exc_addr_d    = in_rob_miss_addr;
            exc_cause_d   = in_rob_exception;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    // State and registered outputs; reset returns to RUN with everything cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= {CNT_W{1'b0}};
            rf_we_q       <= 1'b0;
            rf_rd_q       <= 5'd0;
            rf_data_q     <= 32'h0000_0000;
            sb_commit_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            exc_pc_q      <= 32'h0000_0000;
            exc_addr_q    <= 32'h0000_0000;
            exc_cause_q   <= 3'b000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rf_we_q       <= rf_we_d;
            rf_rd_q       <= rf_rd_d;
            rf_data_q     <= rf_data_d;
            sb_commit_q   <= sb_commit_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            exc_pc_q      <= exc_pc_d;
            exc_addr_q    <= exc_addr_d;
            exc_cause_q   <= exc_cause_d;
        end
    end

    assign out_rf_we       = rf_we_q;
    assign out_rf_rd       = rf_rd_q;
    assign out_rf_data     = rf_data_q;
    assign out_sb_commit   = sb_commit_q;
    assign out_flush       = flush_q;
    assign out_redirect    = redirect_q;
    assign out_redirect_PC = redirect_pc_q;
    assign out_exc_PC      = exc_pc_q;
    assign out_exc_addr    = exc_addr_q;
    assign out_exc_cause   = exc_cause_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [15:0] exc_cnt_q;

    // Performance counters: wrap naturally, same timing as the write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_q <= 32'd0;
            exc_cnt_q     <= 16'd0;
        end else if (retire_s && !exc_s) begin
            retired_cnt_q <= retired_cnt_q + 32'd1;
        end else if (retire_s && exc_s) begin
            exc_cnt_q     <= exc_cnt_q + 16'd1;
        end else begin
            retired_cnt_q <= retired_cnt_q;
        end
    end

    assign out_retired_cnt = retired_cnt_q;
    assign out_exc_cnt     = exc_cnt_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed, table-driven bench for commit_unit plus hand-written sequences
// for the exception/flush, stall and reset-during-flush corner cases.
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_rob_ready;
    logic [31:0] in_rob_value;
    logic [31:0] in_rob_miss_addr;
    logic [31:0] in_rob_PC;
    logic [4:0]  in_rob_rd;
    logic [2:0]  in_rob_exception;
    logic [2:0]  in_rob_instr_type;
    logic        in_stall;
    logic        out_rob_pop;
    logic        out_rf_we;
    logic [4:0]  out_rf_rd;
    logic [31:0] out_rf_data;
    logic        out_sb_commit;
    logic        out_flush;
    logic        out_redirect;
    logic [31:0] out_redirect_PC;
    logic [31:0] out_exc_PC;
    logic [31:0] out_exc_addr;
    logic [2:0]  out_exc_cause;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] out_retired_cnt;
    logic [15:0] out_exc_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    commit_unit dut (
        .clk               (clk),
        .reset             (reset),
        .in_rob_ready      (in_rob_ready),
        .in_rob_value      (in_rob_value),
        .in_rob_miss_addr  (in_rob_miss_addr),
        .in_rob_PC         (in_rob_PC),
        .in_rob_rd         (in_rob_rd),
        .in_rob_exception  (in_rob_exception),
        .in_rob_instr_type (in_rob_instr_type),
        .in_stall          (in_stall),
        .out_rob_pop       (out_rob_pop),
        .out_rf_we         (out_rf_we),
        .out_rf_rd         (out_rf_rd),
        .out_rf_data       (out_rf_data),
        .out_sb_commit     (out_sb_commit),
        .out_flush         (out_flush),
        .out_redirect      (out_redirect),
        .out_redirect_PC   (out_redirect_PC),
        .out_exc_PC        (out_exc_PC),
        .out_exc_addr      (out_exc_addr),
`ifdef COMMIT_PERF_CNT_EN
        .out_exc_cause     (out_exc_cause),
        .out_retired_cnt   (out_retired_cnt),
        .out_exc_cnt       (out_exc_cnt)
`else
        .out_exc_cause     (out_exc_cause)
`endif
    );

    typedef struct {
        logic        ready;
        logic        stall;
        logic [2:0]  ityp;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pop;
        logic        we;
        logic        sb;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic [2:0] exc,
                         input logic [2:0] ityp, input logic [4:0] rd,
                         input logic [31:0] val, input logic [31:0] pc,
                         input logic [31:0] miss);
        in_rob_ready      = rdy;
        in_stall          = stl;
        in_rob_exception  = exc;
        in_rob_instr_type = ityp;
        in_rob_rd         = rd;
        in_rob_value      = val;
        in_rob_PC         = pc;
        in_rob_miss_addr  = miss;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_we"},   {31'd0, out_rf_we},     32'd0);
        chk({tag, "_rf_rd"},   {27'd0, out_rf_rd},     32'd0);
        chk({tag, "_rf_data"}, out_rf_data,            32'd0);
        chk({tag, "_sb"},      {31'd0, out_sb_commit}, 32'd0);
        chk({tag, "_flush"},   {31'd0, out_flush},     32'd0);
        chk({tag, "_redir"},   {31'd0, out_redirect},  32'd0);
        chk({tag, "_redirpc"}, out_redirect_PC,        32'd0);
        chk({tag, "_excpc"},   out_exc_PC,             32'd0);
        chk({tag, "_excaddr"}, out_exc_addr,           32'd0);
        chk({tag, "_cause"},   {29'd0, out_exc_cause}, 32'd0);
        chk({tag, "_pop"},     {31'd0, out_rob_pop},   32'd0);
    endtask

    initial begin
        //            ready stall type    rd     value          pop  we   sb
        vecs[0] = '{1'b1, 1'b0, 3'b000, 5'd1,  32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 3'b001, 5'd0,  32'hCAFEBABE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 3'b010, 5'd5,  32'h11111111, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 3'b011, 5'd7,  32'h22222222, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3'b100, 5'd31, 32'h12345678, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 3'b000, 5'd2,  32'h33333333, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 3'b000, 5'd2,  32'h0000A5A5, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 3'b001, 5'd10, 32'h0BADF00D, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 3'b000, 5'd3,  32'h00000001, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 3'b101, 5'd4,  32'h44444444, 1'b1, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Table-driven normal retirement
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ready, vecs[i].stall, 3'd0, vecs[i].ityp, vecs[i].rd,
                  vecs[i].value, 32'h0000_1000, 32'h0);
            #1;
            chk($sformatf("v%0d_pop", i), {31'd0, out_rob_pop}, {31'd0, vecs[i].pop});
            tick();
            chk($sformatf("v%0d_we", i), {31'd0, out_rf_we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_sb", i), {31'd0, out_sb_commit}, {31'd0, vecs[i].sb});
            chk($sformatf("v%0d_flush", i), {31'd0, out_flush}, 32'd0);
            chk($sformatf("v%0d_redir", i), {31'd0, out_redirect}, 32'd0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_rd", i), {27'd0, out_rf_rd}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_data", i), out_rf_data, vecs[i].value);
            end
        end

        // Exception retire, flush for two cycles, RUN on the third
        drive(1'b1, 1'b0, 3'b001, 3'b000, 5'd3, 32'h55555555, 32'h0000_1008, 32'hFFFF_0000);
        #1;
        chk("exc_pop", {31'd0, out_rob_pop}, 32'd1);
        tick();
        chk("exc_flush1",  {31'd0, out_flush},     32'd1);
        chk("exc_redir1",  {31'd0, out_redirect},  32'd1);
        chk("exc_redirpc", out_redirect_PC,        32'h0000_2000);
        chk("exc_pc",      out_exc_PC,             32'h0000_1008);
        chk("exc_addr",    out_exc_addr,           32'hFFFF_0000);
        chk("exc_cause",   {29'd0, out_exc_cause}, 32'd1);
        chk("exc_we",      {31'd0, out_rf_we},     32'd0);
        chk("exc_sb",      {31'd0, out_sb_commit}, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 3'b000, 5'd4, 32'h66666666, 32'h0000_100C, 32'h0);
        #1;
        chk("fl1_pop", {31'd0, out_rob_pop}, 32'd0);
        tick();
        chk("fl2_flush", {31'd0, out_flush},    32'd1);
        chk("fl2_redir", {31'd0, out_redirect}, 32'd0);
        chk("fl2_we",    {31'd0, out_rf_we},    32'd0);
        chk("fl2_pop",   {31'd0, out_rob_pop},  32'd0);
        tick();
        chk("run_flush", {31'd0, out_flush},   32'd0);
        chk("run_pop",   {31'd0, out_rob_pop}, 32'd1);
        tick();
        chk("run_we",   {31'd0, out_rf_we},  32'd1);
        chk("run_data", out_rf_data,         32'h66666666);
        chk("hold_pc",  out_exc_PC,          32'h0000_1008);

        // Stall holds a ready head for 3 cycles, then it retires
        drive(1'b1, 1'b1, 3'd0, 3'b000, 5'd9, 32'h77777777, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_pop", i), {31'd0, out_rob_pop}, 32'd0);
            tick();
            chk($sformatf("stall%0d_we", i), {31'd0, out_rf_we}, 32'd0);
        end
        in_stall = 1'b0;
        #1;
        chk("unstall_pop", {31'd0, out_rob_pop}, 32'd1);
        tick();
        chk("unstall_we", {31'd0, out_rf_we},  32'd1);
        chk("unstall_rd", {27'd0, out_rf_rd},  32'd9);

        // Stalled exception head waits, then retires once stall drops
        drive(1'b1, 1'b1, 3'b101, 3'b010, 5'd0, 32'h0, 32'h0000_2222, 32'h0000_3333);
        #1;
        chk("sexc_pop0", {31'd0, out_rob_pop}, 32'd0);
        tick();
        chk("sexc_flush0", {31'd0, out_flush},     32'd0);
        chk("sexc_sb0",    {31'd0, out_sb_commit}, 32'd0);
        in_stall = 1'b0;
        #1;
        chk("sexc_pop1", {31'd0, out_rob_pop}, 32'd1);
        tick();
        chk("sexc_flush1", {31'd0, out_flush},     32'd1);
        chk("sexc_sb1",    {31'd0, out_sb_commit}, 32'd0);
        chk("sexc_cause",  {29'd0, out_exc_cause}, 32'd5);
        chk("sexc_pc",     out_exc_PC,             32'h0000_2222);
        in_rob_ready = 1'b0;
        tick();
        tick();
        chk("sexc_done", {31'd0, out_flush}, 32'd0);

        // Reset during FLUSH aborts it
        drive(1'b1, 1'b0, 3'b010, 3'b001, 5'd6, 32'h0, 32'h0000_4444, 32'h0000_5555);
        tick();
        chk("rf_flush_pre", {31'd0, out_flush}, 32'd1);
        reset = 1'b1;
        in_rob_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk_all_zero("midrst");
        in_rob_exception = 3'd0;
        in_rob_ready = 1'b1;
        #1;
        chk("midrst_run_pop", {31'd0, out_rob_pop}, 32'd1);
        tick();

`ifdef COMMIT_PERF_CNT_EN
        do_reset();
        chk("cnt_rst_ret", out_retired_cnt, 32'd0);
        chk("cnt_rst_exc", {16'd0, out_exc_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd0, 3'b000, 5'd1, 32'h0, 32'h0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 3'b011, 3'b000, 5'd1, 32'h0, 32'h0, 32'h0);
        tick();
        in_rob_ready = 1'b0;
        chk("cnt_ret", out_retired_cnt, 32'd4);
        chk("cnt_exc", {16'd0, out_exc_cnt}, 32'd1);
        tick();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
